fifo_prog: RTL

FIFO_PROG -- requirements
Module: fifo_prog

---
 rtl/fifo_prog.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/fifo_prog.sv
// Synchronous FIFO with programmable almost-full/almost-empty thresholds,
// sticky overflow/underflow flags and optional first-word-fall-through output.
module fifo_prog #(
    parameter int unsigned ADDR_WIDTH = 10,
    parameter int unsigned DATA_WIDTH = 64,
    parameter int unsigned SHOWAHEAD  = 0
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  srst,
    input  logic                  wrreq,
    input  logic [DATA_WIDTH-1:0] wrdata,
    input  logic                  rdreq,
    input  logic [ADDR_WIDTH:0]   af_thresh,
    input  logic [ADDR_WIDTH:0]   ae_thresh,
    input  logic                  clr_err,
    output logic [DATA_WIDTH-1:0] rddata,
    output logic [ADDR_WIDTH:0]   level,
    output logic                  wrfull,
    output logic                  rdempty,
    output logic                  almost_full,
    output logic                  almost_empty,
    output logic                  overflow,
    output logic                  underflow
);

    localparam int unsigned           DEPTH   = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0]   DEPTH_L = (ADDR_WIDTH + 1)'(DEPTH);
    localparam logic [ADDR_WIDTH:0]   ONE_L   = (ADDR_WIDTH + 1)'(1);
    localparam logic [ADDR_WIDTH-1:0] ONE_P   = ADDR_WIDTH'(1);

    logic [DATA_WIDTH-1:0] mem [DEPTH];

    logic [ADDR_WIDTH-1:0] wptr_q, wptr_d;
    logic [ADDR_WIDTH-1:0] rptr_q, rptr_d;
    logic [ADDR_WIDTH:0]   level_q, level_d;
    logic [DATA_WIDTH-1:0] rddata_q, rddata_d;
    logic                  valid_q, valid_d;
    logic                  ovf_q, ovf_d;
    logic                  udf_q, udf_d;

    logic                  wrfull_w;
    logic                  rdempty_w;
    logic                  wr_acc;
    logic                  rd_acc;
    logic                  load;
    logic [ADDR_WIDTH:0]   mem_cnt;

    always_comb begin
        wrfull_w  = (level_q == DEPTH_L);
        rdempty_w = (SHOWAHEAD != 0) ? ~valid_q : (level_q == '0);
        wr_acc    = wrreq & ~wrfull_w & ~srst;
        rd_acc    = rdreq & ~rdempty_w & ~srst;
        // In show-ahead mode level also counts the word parked in rddata_q,
        // so only level minus that word is still waiting in the array.
        mem_cnt   = level_q - {{ADDR_WIDTH{1'b0}}, valid_q};
        if (SHOWAHEAD != 0) begin
            load = (~valid_q | rd_acc) & (mem_cnt != '0) & ~srst;
        end else begin
            load = rd_acc;
        end
    end

    always_comb begin
        wptr_d   = wptr_q;
        rptr_d   = rptr_q;
        level_d  = level_q;
        rddata_d = rddata_q;
        valid_d  = valid_q;
        ovf_d    = ovf_q;
        udf_d    = udf_q;

        if (wr_acc) begin
            wptr_d = wptr_q + ONE_P;
        end
        if (load) begin
            rptr_d   = rptr_q + ONE_P;
            rddata_d = mem[rptr_q];
        end

        if (SHOWAHEAD != 0) begin
            if (load) begin
                valid_d = 1'b1;
            end else if (rd_acc) begin
                valid_d = 1'b0;
            end
        end else begin
            valid_d = 1'b0;
        end

        case ({wr_acc, rd_acc})
            2'b10:   level_d = level_q + ONE_L;
            2'b01:   level_d = level_q - ONE_L;
            default: level_d = level_q;
        endcase

        // A set event wins over a clear in the same cycle.
        if (wrreq & wrfull_w) begin
            ovf_d = 1'b1;
        end else if (clr_err) begin
            ovf_d = 1'b0;
        end
        if (rdreq & rdempty_w) begin
            udf_d = 1'b1;
        end else if (clr_err) begin
            udf_d = 1'b0;
        end

        if (srst) begin
            wptr_d   = '0;
            rptr_d   = '0;
            level_d  = '0;
            rddata_d = '0;
            valid_d  = 1'b0;
            ovf_d    = 1'b0;
            udf_d    = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wptr_q   <= '0;
            rptr_q   <= '0;
            level_q  <= '0;
            rddata_q <= '0;
            valid_q  <= 1'b0;
            ovf_q    <= 1'b0;
            udf_q    <= 1'b0;
        end else begin
            wptr_q   <= wptr_d;
            rptr_q   <= rptr_d;
            level_q  <= level_d;
            rddata_q <= rddata_d;
            valid_q  <= valid_d;
            ovf_q    <= ovf_d;
            udf_q    <= udf_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_acc) begin
            mem[wptr_q] <= wrdata;
        end
    end

    assign rddata       = rddata_q;
    assign level        = level_q;
    assign wrfull       = wrfull_w;
    assign rdempty      = rdempty_w;
    assign almost_full  = (level_q >= af_thresh);
    assign almost_empty = (level_q <= ae_thresh);
    assign overflow     = ovf_q;
    assign underflow    = udf_q;

endmodule
